// File: rtl/sound_pkg.sv
// Shared definitions for the sound event sequencer.
// Channel FSM state encoding and channel index constants used by
// sound_event_sequencer and sfx_channel.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    PLAYING  = 2'd2,
    COOLDOWN = 2'd3
  } ch_state_t;

  localparam int CH_SAW    = 0;
  localparam int CH_SQUARE = 1;
  localparam int CH_NOISE  = 2;
  localparam int NUM_CH    = 3;

endpackage

// File: rtl/sfx_channel.sv
// One sound-effect channel: turns a single-cycle event into a frame-aligned
// trigger level lasting FRAMES frame ticks, with retrigger and cooldown.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   ev           single-cycle event pulse
//   frame_tick   single-cycle frame boundary strobe
//   trigger      registered trigger level (high exactly while PLAYING)
//   busy         channel not IDLE
module sfx_channel
  import sound_pkg::*;
#(
  parameter int FRAMES          = 8,
  parameter int COOLDOWN_FRAMES = 2,
  parameter int CNT_W           = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic ev,
  input  logic frame_tick,
  output logic trigger,
  output logic busy
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  generate
    if (FRAMES < 1 || FRAMES > CNT_MAX) begin : g_bad_frames
      $error("sfx_channel: FRAMES out of range for CNT_W");
    end
    if (COOLDOWN_FRAMES < 0 || COOLDOWN_FRAMES > CNT_MAX) begin : g_bad_cd
      $error("sfx_channel: COOLDOWN_FRAMES out of range for CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] PLAY_LOAD = CNT_W'(FRAMES - 1);
  localparam logic [CNT_W-1:0] CD_LOAD   =
    (COOLDOWN_FRAMES > 0) ? CNT_W'(COOLDOWN_FRAMES - 1) : '0;
  localparam bit CD_EN = (COOLDOWN_FRAMES > 0);

  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retrig_q, retrig_d;
  logic             trig_q, trig_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      retrig_q <= 1'b0;
      trig_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retrig_q <= retrig_d;
      trig_q   <= trig_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retrig_d = retrig_q;
    trig_d   = trig_q;
    case (state_q)
      IDLE: begin
        // An event coincident with a tick only arms; the start waits
        // for the following tick so the APU envelope begins on a boundary.
        if (ev) state_d = ARMED;
      end
      ARMED: begin
        if (frame_tick) begin
          state_d = PLAYING;
          cnt_d   = PLAY_LOAD;
          trig_d  = 1'b1;
        end
      end
      PLAYING: begin
        if (frame_tick) begin
          if (retrig_q) begin
            // Retrigger wins over end-of-play on the same tick.
            cnt_d    = PLAY_LOAD;
            retrig_d = 1'b0;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            trig_d = 1'b0;
            if (CD_EN) begin
              state_d = COOLDOWN;
              cnt_d   = CD_LOAD;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end
        end
        // An event on the tick cycle is remembered for the next tick.
        if (ev) retrig_d = 1'b1;
      end
      COOLDOWN: begin
        if (frame_tick) begin
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign trigger = trig_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: rtl/sound_event_sequencer.sv
// Sound event sequencer: converts shoot/hit/explode game events into
// frame-aligned saw/square/noise trigger levels for the APU.
// A frame tick is the first cycle the sync generator sits at pixel (0,0).
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   x, y              current pixel column / row
//   ev_shoot/hit/explode  single-cycle event pulses (saw/square/noise)
//   saw/square/noise_trigger  registered trigger levels to the APU
//   busy              {noise,square,saw} channel not IDLE
// Optional feature macro: SFX_PRIORITY_EN -- while the noise channel plays,
// the saw and square triggers are held low (their channels keep running).
module sound_event_sequencer
  import sound_pkg::*;
#(
  parameter int SAW_FRAMES      = 8,
  parameter int SQUARE_FRAMES   = 16,
  parameter int NOISE_FRAMES    = 32,
  parameter int COOLDOWN_FRAMES = 2,
  parameter int CNT_W           = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       ev_shoot,
  input  logic       ev_hit,
  input  logic       ev_explode,
  output logic       saw_trigger,
  output logic       square_trigger,
  output logic       noise_trigger,
  output logic [2:0] busy
);

  logic              origin, origin_prev, frame_tick;
  logic [NUM_CH-1:0] ev, ch_trig, ch_busy;

  assign origin     = (x == 10'd0) && (y == 10'd0);
  assign frame_tick = origin && !origin_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) origin_prev <= 1'b0;
    else       origin_prev <= origin;
  end

  assign ev[CH_SAW]    = ev_shoot;
  assign ev[CH_SQUARE] = ev_hit;
  assign ev[CH_NOISE]  = ev_explode;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int F = (c == CH_SAW)    ? SAW_FRAMES :
                       (c == CH_SQUARE) ? SQUARE_FRAMES : NOISE_FRAMES;
    sfx_channel #(
      .FRAMES          (F),
      .COOLDOWN_FRAMES (COOLDOWN_FRAMES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .ev         (ev[c]),
      .frame_tick (frame_tick),
      .trigger    (ch_trig[c]),
      .busy       (ch_busy[c])
    );
  end

`ifdef SFX_PRIORITY_EN
  // A channel's trigger register is high exactly while it is PLAYING,
  // so the noise trigger register doubles as the noise-playing flag.
  assign saw_trigger    = ch_trig[CH_SAW]    & ~ch_trig[CH_NOISE];
  assign square_trigger = ch_trig[CH_SQUARE] & ~ch_trig[CH_NOISE];
`else
  assign saw_trigger    = ch_trig[CH_SAW];
  assign square_trigger = ch_trig[CH_SQUARE];
`endif
  assign noise_trigger  = ch_trig[CH_NOISE];
  assign busy           = ch_busy;

endmodule
